// File: rtl/systolic_pkg.sv
// Shared types and elaboration-time helpers for the systolic array feeder.
package systolic_pkg;

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} feeder_state_e;

    // Number of column lanes carried by one B buffer word.
    function automatic int unsigned calc_cols(input int unsigned bus_bytes,
                                              input int unsigned data_bytes);
        return bus_bytes / data_bytes;
    endfunction

    // Drain length: wait until the most-skewed lane has emptied.
    function automatic int unsigned calc_drain(input int unsigned rows,
                                               input int unsigned cols,
                                               input bit          skew_en);
        return skew_en ? ((rows > cols) ? rows : cols) : 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-latency delay for one operand lane; DEPTH 0 is a plain wire.
module skew_delay_line #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_array_feeder.sv
// Streams one tile of A/B buffer words into the systolic array per array_start edge.
// Define FEEDER_SKEW_EN to skew row i / column j by i / j cycles.
module systolic_array_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned BUS_WIDTH_BYTES      = 32,
    parameter int unsigned DATA_WIDTH_BYTES     = 1,
    parameter int unsigned BUFFER_ADDRESS_WIDTH = 10,
    parameter int unsigned ARRAY_HEIGHT         = 4
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         array_start,
    input  logic [15:0]                                  n,
    output logic                                         a_rd_en,
    output logic                                         b_rd_en,
    output logic [BUFFER_ADDRESS_WIDTH-1:0]              a_buffer_rd_addr,
    output logic [BUFFER_ADDRESS_WIDTH-1:0]              b_buffer_rd_addr,
    input  logic [ARRAY_HEIGHT*DATA_WIDTH_BYTES*8-1:0]   a_rd_data,
    input  logic [BUS_WIDTH_BYTES*8-1:0]                 b_rd_data,
    output logic [ARRAY_HEIGHT*DATA_WIDTH_BYTES*8-1:0]   a_row_data,
    output logic [BUS_WIDTH_BYTES*8-1:0]                 b_col_data,
    output logic [ARRAY_HEIGHT-1:0]                      a_row_valid,
    output logic [calc_cols(BUS_WIDTH_BYTES, DATA_WIDTH_BYTES)-1:0] b_col_valid,
    output logic                                         a_half_free,
    output logic                                         b_half_free,
    output logic                                         data_done
);

`ifdef FEEDER_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    localparam int unsigned AW           = BUFFER_ADDRESS_WIDTH;
    localparam int unsigned EW           = DATA_WIDTH_BYTES * 8;
    localparam int unsigned COLS         = calc_cols(BUS_WIDTH_BYTES, DATA_WIDTH_BYTES);
    localparam int unsigned DRAIN_CYCLES = calc_drain(ARRAY_HEIGHT, COLS, SKEW_EN);
    localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

    feeder_state_e      state_q;
    logic               array_start_q;
    logic               rd_en_q;
    logic               vld_q;
    logic               half_q;
    logic               done_q;
    logic [AW-1:0]      ptr_q;
    logic [AW-1:0]      ptr_inc;
    logic [15:0]        remain_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               start;

    assign start   = array_start & ~array_start_q;
    assign ptr_inc = ptr_q + AW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            array_start_q <= 1'b0;
            rd_en_q       <= 1'b0;
            vld_q         <= 1'b0;
            half_q        <= 1'b0;
            done_q        <= 1'b0;
            ptr_q         <= '0;
            remain_q      <= '0;
            drain_q       <= '0;
        end else begin
            array_start_q <= array_start;
            // Buffer returns data one cycle after the strobe.
            vld_q         <= rd_en_q;
            half_q        <= rd_en_q && (ptr_q[AW-1] != ptr_inc[AW-1]);
            done_q        <= 1'b0;
            if (rd_en_q) ptr_q <= ptr_inc;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (n == 16'd0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= StFeed;
                            rd_en_q  <= 1'b1;
                            remain_q <= n - 16'd1;
                        end
                    end
                end
                StFeed: begin
                    if (remain_q == 16'd0) begin
                        state_q <= StDrain;
                        rd_en_q <= 1'b0;
                        drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end else begin
                        remain_q <= remain_q - 16'd1;
                    end
                end
                StDrain: begin
                    if (drain_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_rd_en          = rd_en_q;
    assign b_rd_en          = rd_en_q;
    assign a_buffer_rd_addr = ptr_q;
    assign b_buffer_rd_addr = ptr_q;
    assign a_half_free      = half_q;
    assign b_half_free      = half_q;
    assign data_done        = done_q;

    // Lane data is masked by its valid so idle and reset lanes read as zero.
    for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_row
        logic [EW:0] lane_out;
        skew_delay_line #(
            .DEPTH(SKEW_EN ? i : 0),
            .WIDTH(EW + 1)
        ) u_row_dly (
            .clk    (clk),
            .reset_n(reset_n),
            .din    ({vld_q, a_rd_data[i*EW +: EW]}),
            .dout   (lane_out)
        );
        assign a_row_valid[i]         = lane_out[EW];
        assign a_row_data[i*EW +: EW] = lane_out[EW] ? lane_out[EW-1:0] : '0;
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [EW:0] lane_out;
        skew_delay_line #(
            .DEPTH(SKEW_EN ? j : 0),
            .WIDTH(EW + 1)
        ) u_col_dly (
            .clk    (clk),
            .reset_n(reset_n),
            .din    ({vld_q, b_rd_data[j*EW +: EW]}),
            .dout   (lane_out)
        );
        assign b_col_valid[j]         = lane_out[EW];
        assign b_col_data[j*EW +: EW] = lane_out[EW] ? lane_out[EW-1:0] : '0;
    end

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Randomized bench for systolic_array_feeder against a per-cycle expectation timeline.
module tb_systolic_array_feeder;

    localparam int unsigned BUS_WIDTH_BYTES      = 32;
    localparam int unsigned DATA_WIDTH_BYTES     = 1;
    localparam int unsigned BUFFER_ADDRESS_WIDTH = 10;
    localparam int unsigned ARRAY_HEIGHT         = 4;
    localparam int unsigned EW        = DATA_WIDTH_BYTES * 8;
    localparam int unsigned COLS      = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int unsigned AD_W      = ARRAY_HEIGHT * EW;
    localparam int unsigned BD_W      = BUS_WIDTH_BYTES * 8;
    localparam int          DEPTH_BUF = 1 << BUFFER_ADDRESS_WIDTH;
    localparam int          MAXC      = 4096;
`ifdef FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int DRAIN = SKEW ? ((ARRAY_HEIGHT > COLS) ? ARRAY_HEIGHT : COLS) : 1;

    logic                            clk = 1'b0;
    logic                            reset_n = 1'b0;
    logic                            array_start = 1'b0;
    logic [15:0]                     n = '0;
    logic                            a_rd_en, b_rd_en;
    logic [BUFFER_ADDRESS_WIDTH-1:0] a_buffer_rd_addr, b_buffer_rd_addr;
    logic [AD_W-1:0]                 a_rd_data = '0;
    logic [BD_W-1:0]                 b_rd_data = '0;
    logic [AD_W-1:0]                 a_row_data;
    logic [BD_W-1:0]                 b_col_data;
    logic [ARRAY_HEIGHT-1:0]         a_row_valid;
    logic [COLS-1:0]                 b_col_valid;
    logic                            a_half_free, b_half_free, data_done;

    systolic_array_feeder #(
        .BUS_WIDTH_BYTES     (BUS_WIDTH_BYTES),
        .DATA_WIDTH_BYTES    (DATA_WIDTH_BYTES),
        .BUFFER_ADDRESS_WIDTH(BUFFER_ADDRESS_WIDTH),
        .ARRAY_HEIGHT        (ARRAY_HEIGHT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .array_start     (array_start),
        .n               (n),
        .a_rd_en         (a_rd_en),
        .b_rd_en         (b_rd_en),
        .a_buffer_rd_addr(a_buffer_rd_addr),
        .b_buffer_rd_addr(b_buffer_rd_addr),
        .a_rd_data       (a_rd_data),
        .b_rd_data       (b_rd_data),
        .a_row_data      (a_row_data),
        .b_col_data      (b_col_data),
        .a_row_valid     (a_row_valid),
        .b_col_valid     (b_col_valid),
        .a_half_free     (a_half_free),
        .b_half_free     (b_half_free),
        .data_done       (data_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffers with one cycle of read latency.
    logic [AD_W-1:0] mem_a [DEPTH_BUF];
    logic [BD_W-1:0] mem_b [DEPTH_BUF];
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_buffer_rd_addr];
        if (b_rd_en) b_rd_data <= mem_b[b_buffer_rd_addr];
    end

    // Expected outputs per cycle index.
    logic                            e_rd   [MAXC];
    logic [BUFFER_ADDRESS_WIDTH-1:0] e_addr [MAXC];
    logic                            e_half [MAXC];
    logic                            e_done [MAXC];
    logic [ARRAY_HEIGHT-1:0]         e_av   [MAXC];
    logic [COLS-1:0]                 e_bv   [MAXC];
    logic [AD_W-1:0]                 e_ad   [MAXC];
    logic [BD_W-1:0]                 e_bd   [MAXC];

    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_until = -1;
    int   ptr_m = 0;
    logic lv_prev = 1'b0;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    int   half_a_cnt = 0;
    int   half_b_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            e_rd[c] = 1'b0; e_addr[c] = '0; e_half[c] = 1'b0; e_done[c] = 1'b0;
            e_av[c] = '0; e_bv[c] = '0; e_ad[c] = '0; e_bd[c] = '0;
        end
    endtask

    // A tile accepted in cycle s reads n consecutive words starting at the kept pointer.
    task automatic schedule(input int s, input int nv);
        int p;
        p = ptr_m;
        if (nv == 0) begin
            e_done[s+1] = 1'b1;
            busy_until  = s + 1;
            return;
        end
        for (int k = 0; k < nv; k++) begin
            int c, a, a1;
            c  = s + 1 + k;
            a  = (p + k) % DEPTH_BUF;
            a1 = (a + 1) % DEPTH_BUF;
            e_rd[c]   = 1'b1;
            e_addr[c] = BUFFER_ADDRESS_WIDTH'(a);
            if ((a >= DEPTH_BUF / 2) != (a1 >= DEPTH_BUF / 2)) e_half[c+1] = 1'b1;
            for (int i = 0; i < ARRAY_HEIGHT; i++) begin
                int d;
                d = c + 1 + (SKEW ? i : 0);
                e_av[d][i] = 1'b1;
                e_ad[d][i*EW +: EW] = mem_a[a][i*EW +: EW];
            end
            for (int j = 0; j < COLS; j++) begin
                int d;
                d = c + 1 + (SKEW ? j : 0);
                e_bv[d][j] = 1'b1;
                e_bd[d][j*EW +: EW] = mem_b[a][j*EW +: EW];
            end
        end
        for (int c = s + nv + 1; c < MAXC; c++)
            e_addr[c] = BUFFER_ADDRESS_WIDTH'((p + nv) % DEPTH_BUF);
        e_done[s+nv+DRAIN+1] = 1'b1;
        busy_until = s + nv + DRAIN + 1;
        ptr_m = (p + nv) % DEPTH_BUF;
    endtask

    task automatic compare_cycle();
        check("ctl", 256'({a_rd_en, b_rd_en, a_half_free, b_half_free, data_done}),
              256'({e_rd[cyc], e_rd[cyc], e_half[cyc], e_half[cyc], e_done[cyc]}));
        check("addr", 256'({a_buffer_rd_addr, b_buffer_rd_addr}),
              256'({e_addr[cyc], e_addr[cyc]}));
        check("a_valid", 256'(a_row_valid), 256'(e_av[cyc]));
        check("b_valid", 256'(b_col_valid), 256'(e_bv[cyc]));
        check("a_data", 256'(a_row_data), 256'(e_ad[cyc]));
        check("b_data", 256'(b_col_data), 256'(e_bd[cyc]));
        if (data_done) done_cnt++;
        if (a_rd_en) rd_cnt++;
        if (a_half_free) half_a_cnt++;
        if (b_half_free) half_b_cnt++;
    endtask

    task automatic step(input logic st, input logic [15:0] nv);
        @(negedge clk);
        if (cyc >= MAXC - 64) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 64);
            $fatal(1, "cycle budget exhausted");
        end
        compare_cycle();
        array_start = st;
        n = nv;
        if (reset_n && st && !lv_prev && cyc > busy_until) schedule(cyc, int'(nv));
        lv_prev = reset_n ? st : 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= busy_until) step(1'b0, 16'($urandom_range(0, 65535)));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        compare_cycle();
        array_start = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_ctl", 256'({a_rd_en, b_rd_en, a_half_free, b_half_free, data_done,
                               a_buffer_rd_addr, b_buffer_rd_addr}), 256'(0));
        check("rst_lanes", 256'({a_row_valid, b_col_valid, a_row_data}), 256'(0));
        check("rst_bdata", 256'(b_col_data), 256'(0));
        clear_from(cyc + 1);
        ptr_m = 0;
        lv_prev = 1'b0;
        busy_until = cyc;
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        int d0, r0, ha0, hb0;
        logic lv;
        clear_from(0);
        for (int i = 0; i < DEPTH_BUF; i++) begin
            mem_a[i] = AD_W'($urandom);
            for (int w = 0; w < BD_W / 32; w++) mem_b[i][w*32 +: 32] = $urandom;
        end

        pulse_reset();
        step(1'b0, 16'd0);

        // Zero-length tile: no strobes, a single data_done.
        d0 = done_cnt; r0 = rd_cnt;
        step(1'b1, 16'd0);
        repeat (4) step(1'b0, 16'd0);
        check("n0_done", 256'(done_cnt - d0), 256'(1));
        check("n0_reads", 256'(rd_cnt - r0), 256'(0));

        // Plain eight-word tile.
        d0 = done_cnt; r0 = rd_cnt;
        step(1'b1, 16'd8);
        wait_idle();
        check("n8_reads", 256'(rd_cnt - r0), 256'(8));
        check("n8_done", 256'(done_cnt - d0), 256'(1));

        // Start level held across DONE, then a second edge.
        d0 = done_cnt;
        step(1'b1, 16'd5);
        while (cyc <= busy_until + 3) step(1'b1, 16'($urandom_range(1, 9)));
        step(1'b0, 16'd3);
        step(1'b1, 16'd3);
        wait_idle();
        check("held_start_tiles", 256'(done_cnt - d0), 256'(2));

        // Rising edge landing in the DONE cycle is dropped.
        d0 = done_cnt;
        step(1'b1, 16'd4);
        while (cyc + 1 < busy_until) step(1'b0, 16'd4);
        step(1'b1, 16'd4);
        step(1'b0, 16'd4);
        wait_idle();
        check("done_coincide", 256'(done_cnt - d0), 256'(1));

        // Reset during the third FEED cycle, then restart from address 0.
        d0 = done_cnt;
        step(1'b1, 16'd8);
        step(1'b0, 16'd8);
        step(1'b0, 16'd8);
        pulse_reset();
        repeat (DRAIN + 10) step(1'b0, 16'd0);
        check("rst_no_done", 256'(done_cnt - d0), 256'(0));
        step(1'b1, 16'd6);
        wait_idle();

        // Random start levels and n values.
        lv = 1'b0;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) lv = ~lv;
            step(lv, 16'($urandom_range(0, 12)));
        end
        wait_idle();

        // Walk the pointer to 1020 and read across the wrap.
        if (ptr_m != 1020) begin
            step(1'b1, 16'((1020 - ptr_m + DEPTH_BUF) % DEPTH_BUF));
            wait_idle();
        end
        ha0 = half_a_cnt; hb0 = half_b_cnt;
        step(1'b1, 16'd8);
        wait_idle();
        check("wrap_half_a", 256'(half_a_cnt - ha0), 256'(1));
        check("wrap_half_b", 256'(half_b_cnt - hb0), 256'(1));
        check("wrap_ptr", 256'(a_buffer_rd_addr), 256'(4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
